usb_protocol_fsm: RTL and testbench

Consumes transactions from the read/write task FSM (OUT/IN token plus payload) and executes them as USB packet exchanges: token, data, handshake. Drives the packet-layer transmitter and monitors the packet-layer receiver. Handles timeouts, NAK and error retries, and data return. Each transaction is completed to the upstream stage with a one-cycle trans_taken pulse that carries success and the read data.

---
 rtl/usb_pkg.sv | 26 ++
 rtl/usb_timeout_timer.sv | 31 +++
 rtl/usb_protocol_fsm.sv | 194 +++++++++++++++++++
 tb/tb_usb_protocol_fsm.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB protocol definitions: PID codes and the
// protocol FSM state encoding.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_TOKEN,
    S_TX_DATA,
    S_WAIT_HS,
    S_WAIT_DATA,
    S_TX_ACK,
    S_TX_NAK,
    S_DONE
  } usb_state_t;

  function automatic logic is_token(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN);
  endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Response timeout counter: cleared on the last transmitted
// packet, counts while waiting, saturates at the limit.
module usb_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Saturating wait counter; never wraps back to zero
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/usb_protocol_fsm.sv
// USB transaction engine: token, data and handshake
// exchanges with NAK/error/timeout retries.
module usb_protocol_fsm
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_ATTEMPTS   = 8
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        trans_avail,
  input  logic [3:0]  pid,
  input  logic [3:0]  endp,
  input  logic [6:0]  addr,
  input  logic [63:0] data_field,
  output logic        trans_taken,
  output logic        success,
  output logic [63:0] data_read,
  output logic        tx_start,
  output logic [3:0]  tx_pid,
  output logic [6:0]  tx_addr,
  output logic [3:0]  tx_endp,
  output logic [63:0] tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_err
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_ATTEMPTS);

  usb_state_t    state;
  logic [3:0]    lat_pid;
  logic [AW-1:0] attempt;
  logic [63:0]   cap;
  logic          expired;
  logic          tmr_clr;
  logic          tmr_en;
  logic          fail;
  logic          retry;

  assign tmr_clr = tx_done &&
                   ((state == S_TX_TOKEN) ||
                    (state == S_TX_DATA));
  assign tmr_en  = (state == S_WAIT_HS) ||
                   (state == S_WAIT_DATA);
  assign retry   = (attempt < MAX_A);

  usb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_L  (rst_L),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(expired)
  );

  // Attempt failure; a received packet beats a timeout
  always_comb begin
    fail = 1'b0;
    case (state)
      S_WAIT_HS:
        fail = rx_valid ? (rx_err || (rx_pid != PID_ACK))
                        : expired;
      S_WAIT_DATA:
        fail = rx_valid ? (!rx_err && (rx_pid != PID_DATA0))
                        : expired;
      S_TX_NAK:
        fail = tx_done;
      default:
        fail = 1'b0;
    endcase
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state       <= S_IDLE;
      lat_pid     <= '0;
      attempt     <= '0;
      cap         <= '0;
      trans_taken <= 1'b0;
      success     <= 1'b0;
      data_read   <= '0;
      tx_start    <= 1'b0;
      tx_pid      <= '0;
      tx_addr     <= '0;
      tx_endp     <= '0;
      tx_data     <= '0;
    end else begin
      trans_taken <= 1'b0;
      if (fail) begin
        if (retry) begin
          attempt  <= attempt + 1'b1;
          state    <= S_TX_TOKEN;
          tx_start <= 1'b1;
          tx_pid   <= lat_pid;
        end else begin
          state       <= S_DONE;
          tx_start    <= 1'b0;
          trans_taken <= 1'b1;
          success     <= 1'b0;
          data_read   <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (trans_avail) begin
              lat_pid <= pid;
              tx_addr <= addr;
              tx_endp <= endp;
              tx_data <= data_field;
              attempt <= AW'(1);
              if (is_token(pid)) begin
                state    <= S_TX_TOKEN;
                tx_start <= 1'b1;
                tx_pid   <= pid;
              end else begin
                state       <= S_DONE;
                trans_taken <= 1'b1;
                success     <= 1'b0;
                data_read   <= '0;
              end
            end
          end
          S_TX_TOKEN: begin
            if (tx_done) begin
              if (lat_pid == PID_OUT) begin
                state  <= S_TX_DATA;
                tx_pid <= PID_DATA0;
              end else begin
                state    <= S_WAIT_DATA;
                tx_start <= 1'b0;
              end
            end
          end
          S_TX_DATA: begin
            if (tx_done) begin
              state    <= S_WAIT_HS;
              tx_start <= 1'b0;
            end
          end
          S_WAIT_HS: begin
            if (rx_valid) begin
              state       <= S_DONE;
              trans_taken <= 1'b1;
              success     <= 1'b1;
              data_read   <= '0;
            end
          end
          S_WAIT_DATA: begin
            if (rx_valid) begin
              tx_start <= 1'b1;
              if (rx_err) begin
                state  <= S_TX_NAK;
                tx_pid <= PID_NAK;
              end else begin
                cap    <= rx_data;
                state  <= S_TX_ACK;
                tx_pid <= PID_ACK;
              end
            end
          end
          S_TX_ACK: begin
            if (tx_done) begin
              state       <= S_DONE;
              tx_start    <= 1'b0;
              trans_taken <= 1'b1;
              success     <= 1'b1;
              data_read   <= cap;
            end
          end
          S_TX_NAK: begin
            state <= S_TX_NAK;
          end
          S_DONE: begin
            state     <= S_IDLE;
            success   <= 1'b0;
            data_read <= '0;
            tx_pid    <= '0;
            tx_addr   <= '0;
            tx_endp   <= '0;
            tx_data   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Bench for usb_protocol_fsm: packet-layer emulator plus a
// transaction-level model of the retry rules.
module tb_usb_protocol_fsm;
  import usb_pkg::*;

  localparam int T = 16;
  localparam int A = 3;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        trans_avail = 1'b0;
  logic [3:0]  pid = '0;
  logic [3:0]  endp = '0;
  logic [6:0]  addr = '0;
  logic [63:0] data_field = '0;
  logic        trans_taken;
  logic        success;
  logic [63:0] data_read;
  logic        tx_start;
  logic [3:0]  tx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic [63:0] tx_data;
  logic        tx_done = 1'b0;
  logic        rx_valid = 1'b0;
  logic [3:0]  rx_pid = '0;
  logic [63:0] rx_data = '0;
  logic        rx_err = 1'b0;

  typedef struct {
    bit          none;
    int          j;
    logic [3:0]  pid;
    logic [63:0] data;
    bit          err;
  } resp_t;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;

  resp_t resp_q[$];
  pkt_t  pkt_q[$];
  pkt_t  exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int taken_cnt = 0;
  int taken_cyc = -1;
  int last_rx_cyc = -1;

  always #5 clk = ~clk;

  usb_protocol_fsm #(
    .TIMEOUT_CYCLES(T),
    .MAX_ATTEMPTS(A)
  ) dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .trans_avail(trans_avail),
    .pid        (pid),
    .endp       (endp),
    .addr       (addr),
    .data_field (data_field),
    .trans_taken(trans_taken),
    .success    (success),
    .data_read  (data_read),
    .tx_start   (tx_start),
    .tx_pid     (tx_pid),
    .tx_addr    (tx_addr),
    .tx_endp    (tx_endp),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .rx_valid   (rx_valid),
    .rx_pid     (rx_pid),
    .rx_data    (rx_data),
    .rx_err     (rx_err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (trans_taken === 1'b1) begin
      taken_cnt++;
      taken_cyc = cyc;
    end
  end

  // Packet layer: each packet takes 3 cycles; the device
  // answers j cycles into the wait window (j=0 first cycle).
  initial begin
    int cnt;
    int rcd;
    logic [3:0] cur;
    resp_t r;
    cnt = 0;
    rcd = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      rx_valid = 1'b0;
      if (rcd != 0) begin
        rcd--;
        if (rcd == 0) begin
          rx_valid = 1'b1;
          last_rx_cyc = cyc;
        end
      end
      if (!rst_L) begin
        cnt = 0;
        rcd = 0;
        rx_valid = 1'b0;
      end else if (tx_start === 1'b1) begin
        if (cnt == 0) begin
          cur = tx_pid;
          pkt_q.push_back('{tx_pid, tx_addr,
                            tx_endp, tx_data});
        end
        if (cnt == 2) begin
          tx_done = 1'b1;
          cnt = 0;
          if ((cur == PID_DATA0 || cur == PID_IN) &&
              resp_q.size() > 0) begin
            r = resp_q.pop_front();
            if (!r.none) begin
              rcd = r.j + 1;
              rx_pid = r.pid;
              rx_data = r.data;
              rx_err = r.err;
            end
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  function automatic resp_t mk(input bit nn, input int j,
                               input logic [3:0] p,
                               input logic [63:0] d,
                               input bit e);
    resp_t r;
    r.none = nn;
    r.j = j;
    r.pid = p;
    r.data = d;
    r.err = e;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: packets sent and result
  task automatic model(input logic [3:0] p,
                       input logic [6:0] a,
                       input logic [3:0] e,
                       input logic [63:0] d,
                       input resp_t rq[$],
                       output logic es,
                       output logic [63:0] ed);
    resp_t r;
    bit inwin;
    exp_q.delete();
    es = 1'b0;
    ed = '0;
    if (p != PID_OUT && p != PID_IN) return;
    for (int att = 0; att < A; att++) begin
      if (att < rq.size()) r = rq[att];
      else r = mk(1, 0, '0, '0, 0);
      inwin = !r.none && (r.j <= T);
      exp_q.push_back('{p, a, e, d});
      if (p == PID_OUT) begin
        exp_q.push_back('{PID_DATA0, a, e, d});
        if (inwin && !r.err && r.pid == PID_ACK) begin
          es = 1'b1;
          return;
        end
      end else begin
        if (inwin && !r.err && r.pid == PID_DATA0) begin
          exp_q.push_back('{PID_ACK, a, e, d});
          es = 1'b1;
          ed = r.data;
          return;
        end
        if (inwin && r.err)
          exp_q.push_back('{PID_NAK, a, e, d});
      end
    end
  endtask

  task automatic run(input string tag,
                     input logic [3:0] p,
                     input logic [6:0] a,
                     input logic [3:0] e,
                     input logic [63:0] d);
    resp_t rq[$];
    logic es;
    logic [63:0] ed;
    logic gs;
    logic [63:0] gd;
    int n;
    int t0;
    int m;
    rq = resp_q;
    model(p, a, e, d, rq, es, ed);
    pkt_q.delete();
    t0 = taken_cnt;
    @(negedge clk);
    pid = p;
    addr = a;
    endp = e;
    data_field = d;
    trans_avail = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trans_taken !== 1'b1 && n < 3000);
    gs = success;
    gd = data_read;
    trans_avail = 1'b0;
    repeat (T + 6) @(negedge clk);
    chk({tag, ":bound"}, 64'(n < 3000), 64'd1);
    chk({tag, ":pulses"}, 64'(taken_cnt - t0), 64'd1);
    chk({tag, ":success"}, 64'(gs), 64'(es));
    chk({tag, ":data_read"}, gd, ed);
    chk({tag, ":npkts"}, 64'(pkt_q.size()),
        64'(exp_q.size()));
    m = (pkt_q.size() < exp_q.size()) ? pkt_q.size()
                                       : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, ":pkt_pid"}, 64'(pkt_q[i].pid),
          64'(exp_q[i].pid));
      if (exp_q[i].pid == PID_OUT ||
          exp_q[i].pid == PID_IN)
        chk({tag, ":tok_ae"},
            64'({pkt_q[i].addr, pkt_q[i].endp}),
            64'({exp_q[i].addr, exp_q[i].endp}));
      if (exp_q[i].pid == PID_DATA0)
        chk({tag, ":pkt_data"}, pkt_q[i].data,
            exp_q[i].data);
    end
    resp_q.delete();
  endtask

  initial begin
    int n;
    int t0;
    int k;
    logic [3:0] p;
    logic [3:0] good;

    #1;
    chk("rst_ctl", 64'({trans_taken, success, tx_start,
                        tx_pid, tx_addr, tx_endp}), 64'd0);
    chk("rst_dr", data_read, 64'd0);
    chk("rst_td", tx_data, 64'd0);
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    resp_q.push_back(mk(0, 10, PID_ACK, '0, 0));
    run("out_ack", PID_OUT, 7'd5, 4'd4, 64'd80);
    chk("out_latency", 64'(taken_cyc - last_rx_cyc), 64'd1);

    resp_q.push_back(mk(0, 4, PID_DATA0, 64'd90, 0));
    run("in_data", PID_IN, 7'd5, 4'd8, 64'd0);

    resp_q.push_back(mk(0, 2, PID_NAK, '0, 0));
    resp_q.push_back(mk(0, 5, PID_NAK, '0, 0));
    resp_q.push_back(mk(0, 1, PID_ACK, '0, 0));
    run("out_nak2", PID_OUT, 7'h11, 4'd2, 64'hCAFE);

    resp_q.push_back(mk(0, 1, PID_NAK, '0, 0));
    resp_q.push_back(mk(0, 1, PID_NAK, '0, 0));
    resp_q.push_back(mk(0, 1, PID_NAK, '0, 0));
    run("out_nak3", PID_OUT, 7'h12, 4'd3, 64'h77);

    run("in_silent", PID_IN, 7'h20, 4'd1, 64'd0);

    resp_q.push_back(mk(0, 3, PID_DATA0, 64'h1234, 1));
    resp_q.push_back(mk(0, 5, PID_DATA0, 64'hDEAD, 0));
    run("in_err", PID_IN, 7'h21, 4'd6, 64'd0);

    resp_q.push_back(mk(0, T, PID_ACK, '0, 0));
    run("out_edge", PID_OUT, 7'h30, 4'd7, 64'h5A5A);

    for (int i = 0; i < A; i++)
      resp_q.push_back(mk(0, T + 1, PID_ACK, '0, 0));
    run("out_late", PID_OUT, 7'h31, 4'd9, 64'hA5);

    run("bad_pid", 4'b0101, 7'h32, 4'd1, 64'h1);

    pkt_q.delete();
    resp_q.delete();
    t0 = taken_cnt;
    @(negedge clk);
    pid = PID_OUT;
    addr = 7'h3;
    endp = 4'd1;
    data_field = 64'hBEEF;
    trans_avail = 1'b1;
    n = 0;
    while (!(pkt_q.size() == 2 && tx_start === 1'b0) &&
           n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", 64'(n < 200), 64'd1);
    repeat (4) @(negedge clk);
    #2;
    rst_L = 1'b0;
    #1;
    chk("midrst_ctl", 64'({trans_taken, success, tx_start,
                           tx_pid, tx_addr, tx_endp}), 64'd0);
    chk("midrst_dr", data_read, 64'd0);
    chk("midrst_td", tx_data, 64'd0);
    trans_avail = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_taken", 64'(taken_cnt - t0), 64'd0);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);
    resp_q.push_back(mk(0, 6, PID_ACK, '0, 0));
    run("post_rst", PID_OUT, 7'h44, 4'd5, 64'h99);

    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 9);
      if (k <= 4) p = PID_OUT;
      else if (k <= 8) p = PID_IN;
      else p = 4'(3 + 2 * $urandom_range(0, 1));
      good = (p == PID_OUT) ? PID_ACK : PID_DATA0;
      for (int a = 0; a < A; a++) begin
        k = $urandom_range(0, 5);
        case (k)
          0: resp_q.push_back(mk(1, 0, '0, '0, 0));
          1: resp_q.push_back(mk(0, $urandom_range(0, T),
                 good, {$urandom, $urandom}, 0));
          2: resp_q.push_back(mk(0, $urandom_range(0, T),
                 PID_NAK, '0, 0));
          3: resp_q.push_back(mk(0, $urandom_range(0, T),
                 good, {$urandom, $urandom}, 1));
          4: resp_q.push_back(mk(0, T + 1, good,
                 {$urandom, $urandom}, 0));
          default: resp_q.push_back(mk(0,
                 $urandom_range(0, T), PID_IN, '0, 0));
        endcase
      end
      run("rnd", p, 7'($urandom), 4'($urandom),
          {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
